// File: rtl/ctb_pkg.sv
// Shared types and sizing helpers for the compressed-vector trace buffer.
package ctb_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    DRAIN   = 1'b1
  } ctb_state_e;

  localparam int CTB_TB_SIZE_DEF = 16;

  function automatic int ctb_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full buffer (count == depth) is representable.
  function automatic int ctb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CTB_ADDR_W = ctb_addr_w(CTB_TB_SIZE_DEF);
  localparam int CTB_CNT_W  = ctb_cnt_w(CTB_TB_SIZE_DEF);

endpackage

// File: rtl/ctb_mem.sv
// Simple dual-port entry store: synchronous write, one-cycle registered read.
// The array itself is never reset; only the read register is.
module ctb_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 257,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register holds its value between reads so the output is stable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/comp_trace_buffer.sv
// Circular trace buffer for raw/delta-compressed vectors with capture and drain modes.
// Optional macro CTB_WRAP_FLAG_EN adds the 'wrapped' output.
module comp_trace_buffer
  import ctb_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tracing,
  input  logic                            valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]    vector_in,
  input  logic                            v_in_comp,
  input  logic                            inc_tb_ptr,
  input  logic                            rd_req,
  output logic                            rd_valid,
  output logic [N-1:0][DATA_WIDTH-1:0]    vector_out,
  output logic                            v_out_comp,
  output logic                            rd_done,
  output logic [ctb_cnt_w(TB_SIZE)-1:0]   count
`ifdef CTB_WRAP_FLAG_EN
  ,
  output logic                            wrapped
`endif
);

  localparam int AW = ctb_addr_w(TB_SIZE);
  localparam int CW = ctb_cnt_w(TB_SIZE);
  localparam int MW = N * DATA_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(TB_SIZE);

  ctb_state_e      r_state;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_remaining;
  logic            r_rd_valid;

  logic            w_wr_en;
  logic [AW-1:0]   w_wa;
  logic            w_rd_fire;
  logic [MW-1:0]   w_rd_data;

  assign w_wr_en   = (r_state == CAPTURE) && !tracing && valid_in;
  // An empty buffer always restarts at entry 0, whatever inc_tb_ptr says.
  assign w_wa      = (r_count == '0) ? '0 : (inc_tb_ptr ? r_wptr + AW'(1) : r_wptr);
  assign w_rd_fire = (r_state == DRAIN) && tracing && rd_req && (r_remaining != '0);

  ctb_mem #(
    .DEPTH (TB_SIZE),
    .WIDTH (MW),
    .AW    (AW)
  ) u_mem (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wa),
    .i_wr_data ({v_in_comp, vector_in}),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= CAPTURE;
      r_wptr      <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_rd_valid <= 1'b0;
          if (tracing) begin
            // Oldest entry sits just past the write pointer once the buffer has wrapped.
            r_state     <= DRAIN;
            r_rd_ptr    <= (r_count == FULL) ? r_wptr + AW'(1) : '0;
            r_remaining <= r_count;
          end else if (valid_in) begin
            r_wptr <= w_wa;
            if (r_count == '0)
              r_count <= CW'(1);
            else if (inc_tb_ptr && (r_count != FULL))
              r_count <= r_count + CW'(1);
          end
        end
        DRAIN: begin
          if (!tracing) begin
            r_state     <= CAPTURE;
            r_wptr      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_rd_valid  <= 1'b0;
          end else begin
            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
              r_rd_ptr    <= r_rd_ptr + AW'(1);
              r_remaining <= r_remaining - CW'(1);
            end
          end
        end
        default: r_state <= CAPTURE;
      endcase
    end
  end

`ifdef CTB_WRAP_FLAG_EN
  logic r_wrapped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_wrapped <= 1'b0;
    else if ((r_state == DRAIN) && !tracing)
      r_wrapped <= 1'b0;
    else if (w_wr_en && inc_tb_ptr && (r_count == FULL))
      r_wrapped <= 1'b1;
  end

  assign wrapped = r_wrapped;
`endif

  assign rd_valid   = r_rd_valid;
  assign vector_out = w_rd_data[MW-2:0];
  assign v_out_comp = w_rd_data[MW-1];
  assign rd_done    = (r_state == DRAIN) && (r_remaining == '0) && !r_rd_valid;
  assign count      = r_count;

endmodule

// File: tb/tb_comp_trace_buffer.sv
// Directed self-checking bench for comp_trace_buffer (default parameters).
// Checks 'wrapped' only when CTB_WRAP_FLAG_EN is defined.
module tb_comp_trace_buffer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int TS = 16;
  localparam int CW = $clog2(TS) + 1;

  typedef logic [256:0] w_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 tracing;
  logic                 valid_in;
  logic [N-1:0][DW-1:0] vector_in;
  logic                 v_in_comp;
  logic                 inc_tb_ptr;
  logic                 rd_req;
  logic                 rd_valid;
  logic [N-1:0][DW-1:0] vector_out;
  logic                 v_out_comp;
  logic                 rd_done;
  logic [CW-1:0]        count;
`ifdef CTB_WRAP_FLAG_EN
  logic                 wrapped;
`endif

  int n_checks = 0;
  int n_errors = 0;

  comp_trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .vector_in  (vector_in),
    .v_in_comp  (v_in_comp),
    .inc_tb_ptr (inc_tb_ptr),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .vector_out (vector_out),
    .v_out_comp (v_out_comp),
    .rd_done    (rd_done),
    .count      (count)
`ifdef CTB_WRAP_FLAG_EN
    ,
    .wrapped    (wrapped)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0][DW-1:0] mkvec(input int v);
    logic [N-1:0][DW-1:0] r;
    for (int i = 0; i < N; i++) r[i] = DW'(v * 16 + i);
    return r;
  endfunction

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int v, input logic inc);
    valid_in   = 1'b1;
    vector_in  = mkvec(v);
    v_in_comp  = v[0];
    inc_tb_ptr = inc;
    tick();
    valid_in   = 1'b0;
  endtask

  task automatic do_read(input string tag, input int v);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({tag, "_valid"}, w_t'(rd_valid), w_t'(1'b1));
    chk({tag, "_data"}, w_t'(vector_out), w_t'(mkvec(v)));
    chk({tag, "_comp"}, w_t'(v_out_comp), w_t'(v[0]));
  endtask

  task automatic enter_drain();
    tracing = 1'b1;
    tick();
  endtask

  task automatic exit_drain();
    tracing = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tracing = 1'b0; valid_in = 1'b0; vector_in = '0;
    v_in_comp = 1'b0; inc_tb_ptr = 1'b0; rd_req = 1'b0;
    tick(); tick();
    chk("rst_count", w_t'(count), w_t'(0));
    chk("rst_rd_valid", w_t'(rd_valid), w_t'(0));
    chk("rst_rd_done", w_t'(rd_done), w_t'(0));
    chk("rst_vector_out", w_t'(vector_out), w_t'(0));
    chk("rst_v_out_comp", w_t'(v_out_comp), w_t'(0));
    reset = 1'b0;
    tick();

    // Five incrementing writes, then drain them in order
    for (int i = 1; i <= 5; i++) do_write(i, 1'b1);
    chk("t1_count", w_t'(count), w_t'(5));
    enter_drain();
    chk("t1_done_early", w_t'(rd_done), w_t'(0));
    for (int i = 1; i <= 5; i++) do_read("t1_rd", i);
    chk("t1_done_inflight", w_t'(rd_done), w_t'(0));
    tick();
    chk("t1_done", w_t'(rd_done), w_t'(1));
    chk("t1_idle_valid", w_t'(rd_valid), w_t'(0));
    chk("t1_hold_data", w_t'(vector_out), w_t'(mkvec(5)));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t1_extra_valid", w_t'(rd_valid), w_t'(0));
    chk("t1_extra_done", w_t'(rd_done), w_t'(1));
    exit_drain();
    chk("t1_exit_done", w_t'(rd_done), w_t'(0));
    chk("t1_exit_count", w_t'(count), w_t'(0));

    // Overwrite pattern inc = 1,0,0,0,1,0; valid_in held high throughout drain
    do_write(11, 1'b1); do_write(12, 1'b0); do_write(13, 1'b0);
    do_write(14, 1'b0); do_write(15, 1'b1); do_write(16, 1'b0);
    chk("t2_count", w_t'(count), w_t'(2));
    enter_drain();
    valid_in = 1'b1; vector_in = mkvec(99); inc_tb_ptr = 1'b1; v_in_comp = 1'b1;
    tick();
    chk("t2_drain_count", w_t'(count), w_t'(2));
    do_read("t2_rd0", 14);
    valid_in = 1'b1;
    do_read("t2_rd1", 16);
    valid_in = 1'b1;
    tick();
    chk("t2_done", w_t'(rd_done), w_t'(1));
    chk("t2_count_after", w_t'(count), w_t'(2));
    valid_in = 1'b0;
    exit_drain();

    // Twenty writes wrap the 16-deep buffer; oldest is value 5
    for (int i = 1; i <= 20; i++) do_write(i, 1'b1);
    chk("t3_count", w_t'(count), w_t'(16));
`ifdef CTB_WRAP_FLAG_EN
    chk("t3_wrapped", w_t'(wrapped), w_t'(1));
`endif
    enter_drain();
    for (int i = 5; i <= 20; i++) do_read("t3_rd", i);
    tick();
    chk("t3_done", w_t'(rd_done), w_t'(1));
    exit_drain();
`ifdef CTB_WRAP_FLAG_EN
    chk("t3_wrapped_clr", w_t'(wrapped), w_t'(0));
`endif

    // Drain an empty buffer
    enter_drain();
    chk("t4_done", w_t'(rd_done), w_t'(1));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t4_no_valid", w_t'(rd_valid), w_t'(0));
    exit_drain();

    // Reset mid-drain, then a fresh write lands at entry 0
    for (int i = 31; i <= 35; i++) do_write(i, 1'b1);
    enter_drain();
    do_read("t5_rd0", 31);
    do_read("t5_rd1", 32);
    reset = 1'b1; tracing = 1'b0;
    #2;
    chk("t5_rst_count", w_t'(count), w_t'(0));
    chk("t5_rst_valid", w_t'(rd_valid), w_t'(0));
    chk("t5_rst_done", w_t'(rd_done), w_t'(0));
    chk("t5_rst_vec", w_t'(vector_out), w_t'(0));
    reset = 1'b0;
    tick();
    chk("t5_capture_done", w_t'(rd_done), w_t'(0));
    do_write(40, 1'b1);
    chk("t5_count", w_t'(count), w_t'(1));
    valid_in = 1'b1; vector_in = mkvec(77); inc_tb_ptr = 1'b1;
    enter_drain();
    valid_in = 1'b0;
    chk("t5_trans_count", w_t'(count), w_t'(1));
    do_read("t5_new", 40);
    tick();
    chk("t5_done", w_t'(rd_done), w_t'(1));
    exit_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comp_trace_buffer.md
COMP_TRACE_BUFFER -- requirements
Module: comp_trace_buffer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving lanes per vector.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving bits per lane.
REQ-003 The block SHALL have parameter TB_SIZE, default 16, giving entry depth; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port tracing, input, 1 bit: 0 means capture mode, 1 means drain mode.
REQ-007 The block SHALL have port valid_in, input, 1 bit: write strobe from the delta compressor.
REQ-008 The block SHALL have port vector_in, input, N x DATA_WIDTH: the raw or compressed vector.
REQ-009 The block SHALL have port v_in_comp, input, 1 bit: flag stored with each entry.
REQ-010 The block SHALL have port inc_tb_ptr, input, 1 bit: 1 writes a new entry, 0 overwrites the current entry.
REQ-011 The block SHALL have port rd_req, input, 1 bit: drain read request.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: read data valid.
REQ-013 The block SHALL have port vector_out, output, N x DATA_WIDTH: read data.
REQ-014 The block SHALL have port v_out_comp, output, 1 bit: the stored flag of the entry being read.
REQ-015 The block SHALL have port rd_done, output, 1 bit: all captured entries have been delivered.
REQ-016 The block SHALL have port count, output, log2(TB_SIZE)+1 bits: number of valid entries.

Function
REQ-017 The FSM SHALL have exactly two states, CAPTURE and DRAIN, and SHALL move CAPTURE to DRAIN on the first edge with tracing=1 and DRAIN to CAPTURE on the first edge with tracing=0.
REQ-018 In CAPTURE, each edge with valid_in=1 SHALL write {v_in_comp, vector_in} at write address wa, where wa=0 if count=0, else wptr+1 mod TB_SIZE if inc_tb_ptr=1, else wptr; wptr SHALL then take the value wa.
REQ-019 count SHALL go 0 to 1 on any write, increment on a write with inc_tb_ptr=1 and count>0, and saturate at TB_SIZE; a write with inc_tb_ptr=0 SHALL leave a nonzero count unchanged.
REQ-020 Once full, writes with inc_tb_ptr=1 SHALL overwrite the oldest entry (circular wrap) and count SHALL stay at TB_SIZE.
REQ-021 valid_in SHALL be ignored in DRAIN and on the CAPTURE-to-DRAIN transition edge.
REQ-022 On entry to DRAIN, the block SHALL set rd_ptr to the oldest entry (0 if count<TB_SIZE, else wptr+1 mod TB_SIZE) and set remaining to count.
REQ-023 In DRAIN, rd_req=1 with remaining>0 SHALL produce rd_valid=1 one cycle later with that entry's data, advance rd_ptr with wrap, and decrement remaining.
REQ-024 rd_req=1 with remaining=0 SHALL be ignored and rd_valid SHALL stay 0.
REQ-025 rd_done SHALL be 1 in DRAIN whenever remaining=0 and no read is in flight, including immediately when count=0.
REQ-026 On the DRAIN-to-CAPTURE edge, the block SHALL clear wptr, count and remaining, and rd_valid and rd_done SHALL read 0 from that edge; memory contents SHALL be retained but treated as invalid.
REQ-027 vector_out and v_out_comp SHALL hold their last value when rd_valid=0.

Reset
REQ-028 Asserting reset SHALL immediately force state=CAPTURE, wptr=0, rd_ptr=0, count=0, remaining=0, rd_valid=0, rd_done=0, vector_out=all zeros and v_out_comp=0.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 Reset asserted mid-drain SHALL abort the drain, and after release the block SHALL start in CAPTURE with an empty buffer.

Configuration
REQ-031 With macro CTB_WRAP_FLAG_EN defined, the block SHALL add output wrapped (1 bit), set on any write with inc_tb_ptr=1 while count=TB_SIZE and cleared by reset or the DRAIN-to-CAPTURE edge.
REQ-032 Without CTB_WRAP_FLAG_EN, the wrapped port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-033 Package ctb_pkg SHALL hold the state enum {CAPTURE, DRAIN} and the address-width and count-width constants derived from TB_SIZE.
REQ-034 Storage SHALL be a sub-module ctb_mem: a simple dual-port RAM, TB_SIZE deep and N*DATA_WIDTH+1 bits wide, with synchronous write and a one-cycle registered read.

Verification
REQ-035 With TB_SIZE=16, 5 writes all with inc_tb_ptr=1, then tracing=1 and 5 rd_req, the bench SHALL see entries 0..4 in order, count=5, and rd_done=1 after the 5th rd_valid.
REQ-036 Writes with inc sequence 1,0,0,0,1,0 SHALL give count=2, with entry 0 holding the 4th write and entry 1 holding the 6th write.
REQ-037 20 inc writes of values 1..20 followed by a drain SHALL return 5..20 with count=16 and, with CTB_WRAP_FLAG_EN defined, wrapped=1.
REQ-038 tracing=1 with count=0 SHALL give rd_done=1 on the next cycle, and rd_req SHALL produce no rd_valid.
REQ-039 valid_in=1 held during DRAIN SHALL leave count and data unchanged.
REQ-040 Reset pulsed after 2 of 5 drain reads SHALL give count=0, rd_valid=0, state CAPTURE, and a new write SHALL land at entry 0.
